// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer.
// Holds the channel state enum, a clog2 helper and default parameters.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW,
        RISE_PEND,
        HIGH,
        FALL_PEND
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE      = 4;
    localparam int DEF_LONG_TICKS  = 500;

    // Bits needed to hold values 0..v-1; never less than 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button debouncer bus: tick strobe and raw inputs in, clean events out.
// master drives tick/btn_in; slave (the debouncer) drives the results.
interface btn_debounce_if #(
    parameter int N = 4
);
    logic         tick;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] long_press;

    modport master (
        output tick,
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  long_press
    );

    modport slave (
        input  tick,
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output long_press
    );
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: synchronizer, 4-state FSM, stability counter.
// Ports: clk, rst, tick, btn_in -> level, pressed, released, long_hit.
// Optional hold counter for long_hit is built only with LONG_PRESS_EN.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE      = DEF_STABLE,
    parameter int LONG_TICKS  = DEF_LONG_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic level,
    output logic pressed,
    output logic released,
    output logic long_hit
);

    localparam int CW = clog2(STABLE + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          level_n;
    logic          press_n;
    logic          rel_n;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOW;
            cnt      <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            level    <= level_n;
            pressed  <= press_n;
            released <= rel_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press_n = 1'b0;
        rel_n   = 1'b0;
        if (tick) begin
            unique case (state)
                LOW: begin
                    if (s) begin
                        if (STABLE == 1) begin
                            state_n = HIGH;
                            press_n = 1'b1;
                        end else begin
                            state_n = RISE_PEND;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                RISE_PEND: begin
                    if (!s) begin
                        state_n = LOW;
                        cnt_n   = '0;
                    end else if (cnt == LAST) begin
                        state_n = HIGH;
                        cnt_n   = '0;
                        press_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        if (STABLE == 1) begin
                            state_n = LOW;
                            rel_n   = 1'b1;
                        end else begin
                            state_n = FALL_PEND;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                FALL_PEND: begin
                    if (s) begin
                        state_n = HIGH;
                        cnt_n   = '0;
                    end else if (cnt == LAST) begin
                        state_n = LOW;
                        cnt_n   = '0;
                        rel_n   = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = LOW;
                    cnt_n   = '0;
                end
            endcase
        end
        level_n = (state_n == HIGH) || (state_n == FALL_PEND);
    end

`ifdef LONG_PRESS_EN
    localparam int HW = clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HPRE = HW'(LONG_TICKS - 1);

    logic [HW-1:0] hcnt;
    logic          long_q;

    // Cleared only on a genuine press, so a bounce back from FALL_PEND
    // to HIGH cannot re-arm the pulse within the same press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (press_n) begin
                hcnt <= '0;
            end else if (tick && level && hcnt != HMAX) begin
                hcnt <= hcnt + 1'b1;
                if (hcnt == HPRE) begin
                    long_q <= 1'b1;
                end
            end
        end
    end

    assign long_hit = long_q;
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_TICKS > 0);
    assign long_hit = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// N-channel push-button debouncer driven by a divider tick strobe.
// Ports: clk, rst (async, active-high), bus (btn_debounce_if.slave).
// Define LONG_PRESS_EN to enable the per-channel long_press pulse.
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE      = DEF_STABLE,
    parameter int LONG_TICKS  = DEF_LONG_TICKS
) (
    input  logic          clk,
    input  logic          rst,
    btn_debounce_if.slave bus
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .STABLE     (STABLE),
            .LONG_TICKS (LONG_TICKS)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (bus.tick),
            .btn_in  (bus.btn_in[i]),
            .level   (bus.btn_level[i]),
            .pressed (bus.btn_press[i]),
            .released(bus.btn_release[i]),
            .long_hit(bus.long_press[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: N=4, STABLE=4, LONG_TICKS=8.
// Table-driven steps plus hand sequences for reset and continuous tick.
module tb_btn_debounce;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    btn_debounce_if #(.N(N)) bus ();

    btn_debounce #(
        .N          (N),
        .SYNC_STAGES(2),
        .STABLE     (4),
        .LONG_TICKS (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  btn;
        int          nt;
        logic [3:0]  lvl;
        logic [15:0] prs;
        logic [15:0] rel;
        logic [15:0] lng;
    } vec_t;

    vec_t tbl [17];

    int checks   = 0;
    int failures = 0;
    int pc [N];
    int rc [N];
    int lc [N];
    int both = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clk with the given tick value; tallies pulses after the edge.
    task automatic cyc(input logic t);
        @(negedge clk);
        bus.tick = t;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            pc[i] += int'(bus.btn_press[i]);
            rc[i] += int'(bus.btn_release[i]);
            lc[i] += int'(bus.long_press[i]);
            if (bus.btn_press[i] && bus.btn_release[i]) both++;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            repeat (9) cyc(1'b0);
            cyc(1'b1);
        end
    endtask

    function automatic logic [15:0] pk(input int a0, input int a1,
                                       input int a2, input int a3);
        return {a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
    endfunction

    initial begin
        logic [15:0] exp_l;
        logic [15:0] cur_p;

        tbl[0]  = '{4'b0000, 20, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{4'b0001,  3, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[2]  = '{4'b0001,  1, 4'b0001, 16'h0001, 16'h0000, 16'h0000};
        tbl[3]  = '{4'b0011,  3, 4'b0001, 16'h0001, 16'h0000, 16'h0000};
        tbl[4]  = '{4'b0001,  1, 4'b0001, 16'h0001, 16'h0000, 16'h0000};
        tbl[5]  = '{4'b0011,  3, 4'b0001, 16'h0001, 16'h0000, 16'h0000};
        tbl[6]  = '{4'b0011,  1, 4'b0011, 16'h0011, 16'h0000, 16'h0001};
        tbl[7]  = '{4'b0111,  4, 4'b0111, 16'h0111, 16'h0000, 16'h0001};
        tbl[8]  = '{4'b0111,  3, 4'b0111, 16'h0111, 16'h0000, 16'h0001};
        tbl[9]  = '{4'b0011,  3, 4'b0111, 16'h0111, 16'h0000, 16'h0011};
        tbl[10] = '{4'b0011,  1, 4'b0011, 16'h0111, 16'h0100, 16'h0011};
        tbl[11] = '{4'b1011,  4, 4'b1011, 16'h1111, 16'h0100, 16'h0011};
        tbl[12] = '{4'b1011,  8, 4'b1011, 16'h1111, 16'h0100, 16'h1011};
        tbl[13] = '{4'b1011,  8, 4'b1011, 16'h1111, 16'h0100, 16'h1011};
        tbl[14] = '{4'b0011,  4, 4'b0011, 16'h1111, 16'h1100, 16'h1011};
        tbl[15] = '{4'b1011,  4, 4'b1011, 16'h2111, 16'h1100, 16'h1011};
        tbl[16] = '{4'b1011,  8, 4'b1011, 16'h2111, 16'h1100, 16'h2011};

        for (int i = 0; i < N; i++) begin
            pc[i] = 0;
            rc[i] = 0;
            lc[i] = 0;
        end

        rst        = 1'b1;
        bus.tick   = 1'b0;
        bus.btn_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", 32'(bus.btn_level), 32'h0);
        chk("reset_press", 32'(bus.btn_press), 32'h0);
        chk("reset_release", 32'(bus.btn_release), 32'h0);
        chk("reset_long", 32'(bus.long_press), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 17; k++) begin
            bus.btn_in = tbl[k].btn;
            ticks(tbl[k].nt);
`ifdef LONG_PRESS_EN
            exp_l = tbl[k].lng;
`else
            exp_l = 16'h0000;
`endif
            chk($sformatf("step%0d_level", k),
                32'(bus.btn_level), 32'(tbl[k].lvl));
            chk($sformatf("step%0d_press_cnt", k),
                32'(pk(pc[0], pc[1], pc[2], pc[3])), 32'(tbl[k].prs));
            chk($sformatf("step%0d_release_cnt", k),
                32'(pk(rc[0], rc[1], rc[2], rc[3])), 32'(tbl[k].rel));
            chk($sformatf("step%0d_long_cnt", k),
                32'(pk(lc[0], lc[1], lc[2], lc[3])), 32'(exp_l));
        end

        // Asynchronous reset while buttons are held and accepted.
        @(negedge clk);
        bus.tick = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_level", 32'(bus.btn_level), 32'h0);
        chk("midrst_press", 32'(bus.btn_press), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ticks(3);
        chk("postrst_level_3t", 32'(bus.btn_level), 32'h0);
        ticks(1);
        chk("postrst_level_4t", 32'(bus.btn_level), 32'hb);
        chk("postrst_press_cnt",
            32'(pk(pc[0], pc[1], pc[2], pc[3])), 32'h3122);

        // Release everything, then sample every clk with tick held high.
        bus.btn_in = 4'b0000;
        ticks(4);
        chk("allrel_level", 32'(bus.btn_level), 32'h0);
        chk("allrel_release_cnt",
            32'(pk(rc[0], rc[1], rc[2], rc[3])), 32'h2111);

        bus.btn_in = 4'b0001;
        repeat (5) cyc(1'b1);
        chk("cont_level_5clk", 32'(bus.btn_level), 32'h0);
        cur_p = pk(pc[0], pc[1], pc[2], pc[3]);
        cyc(1'b1);
        chk("cont_level_6clk", 32'(bus.btn_level), 32'h1);
        chk("cont_press_6clk", 32'(bus.btn_press), 32'h1);
        cyc(1'b1);
        chk("cont_press_7clk", 32'(bus.btn_press), 32'h0);
        chk("cont_press_cnt",
            32'(pk(pc[0], pc[1], pc[2], pc[3])), 32'(cur_p + 16'h0001));
        cyc(1'b0);

        chk("press_release_exclusive", 32'(both), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Downstream consumer of the clock divider's single-cycle enable pulse. Uses that pulse as a sample strobe to debounce N asynchronous push-button or switch inputs.
- Each channel produces:
  - a clean level;
  - one-clk press and release pulses;
  - optionally, a long-press pulse.
- Outputs feed the user-interface control logic in the same clock domain.

Parameters:
- N, 4, number of independent input channels.
- SYNC_STAGES, 2, flip-flop synchronizer depth per channel (minimum 2).
- STABLE, 4, consecutive differing tick samples required to accept a new level (minimum 1).
- LONG_TICKS, 500, ticks of continuous high level before long_press fires (used only with LONG_PRESS_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  sample strobe, one clk cycle wide (divider output)
- btn_in  in  N  raw asynchronous button inputs
- btn_level  out  N  debounced level per channel
- btn_press  out  N  one-clk pulse on accepted 0->1
- btn_release  out  N  one-clk pulse on accepted 1->0
- long_press  out  N  one-clk pulse on long hold (tied 0 without LONG_PRESS_EN)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high; every register clears on its rising edge, independent of clk.
- Reset values:
  - btn_level, btn_press, btn_release, long_press = 0;
  - synchronizer flops = 0;
  - per-channel counters = 0;
  - FSM = LOW.
- Synchronizer: btn_in passes through SYNC_STAGES flops on every clk, regardless of tick. The sample s is the last stage.
- Per-channel FSM has four states: LOW, RISE_PEND, HIGH, FALL_PEND. It advances only on clk edges where tick=1; with tick=0 all state, counters and level hold.
- LOW:
  - s=1 with STABLE=1 -> go to HIGH immediately.
  - s=1 otherwise -> go to RISE_PEND, cnt=1.
  - s=0 -> stay in LOW.
- RISE_PEND:
  - s=0 -> back to LOW, cnt=0 (bounce rejected).
  - s=1 and cnt==STABLE-1 -> go to HIGH, cnt=0.
  - s=1 otherwise -> cnt++.
- HIGH and FALL_PEND mirror LOW and RISE_PEND with s inverted.
- btn_level is 1 in HIGH and FALL_PEND, 0 in LOW and RISE_PEND. It is registered and changes on the same edge as the state transition.
- btn_press and btn_release are asserted for exactly the one clk cycle following the transition into HIGH or LOW respectively, and are 0 on all other cycles. They can never both be 1 on one channel.
- Latency: from a clean btn_in edge to btn_level change is SYNC_STAGES clk plus STABLE ticks; the change lands on the STABLE-th consecutive qualifying tick.
- Counter width is clog2(STABLE+1). It never exceeds STABLE-1 and never wraps.
- tick held high continuously is legal: the block then samples every clk.
- Reset mid-press: everything clears. A button still held after reset is reported as a fresh press after SYNC_STAGES clk plus STABLE ticks.
- Channels are fully independent. Simultaneous events on different channels may pulse together.

Optional Feature:
- LONG_PRESS_EN defined:
  - Per-channel hold counter of width clog2(LONG_TICKS+1), cleared on entry to HIGH.
  - Increments on each tick while btn_level=1.
  - When it reaches LONG_TICKS, long_press pulses for one clk and the counter saturates. It fires at most once per press and re-arms only after a release.
  - A release before LONG_TICKS produces no long_press.
- LONG_PRESS_EN undefined: no hold counter is generated and long_press is constant 0.

Decomposition:
- Shared package debounce_pkg holds:
  - the state typedef (LOW, RISE_PEND, HIGH, FALL_PEND);
  - a clog2 constant function;
  - the default STABLE, LONG_TICKS and SYNC_STAGES constants.
- Sub-module debounce_chan implements one channel: synchronizer, FSM, counter and optional hold counter. The top module generates N instances.

Test Plan (N=4, STABLE=4, LONG_TICKS=8, tick every 10 clk):
- Reset, all inputs 0 -> all outputs 0; no pulses over 200 clk.
- btn_in[0] steps 0->1 and holds -> btn_level[0] rises on the 4th tick after sync. btn_press[0] is high exactly one clk. Other channels stay 0.
- btn_in[1] high for 3 ticks, then low, then high again -> no level change during the bounce. The count restarts, and the level rises 4 ticks after the final rise.
- Hold btn_in[2] high for 3 ticks after acceptance, then release -> btn_release[2] pulses one clk 4 ticks after the fall. long_press[2] stays 0.
- With LONG_PRESS_EN, hold btn_in[3] for 20 ticks -> long_press[3] fires once, 8 ticks after btn_level[3] rose. No repeat; it re-arms after release.
- Assert rst while btn_in[0]=1 and btn_level[0]=1 -> outputs clear at once. After rst falls, btn_press[0] re-fires after 2 clk plus 4 ticks.
